compare_pipe_nb: RTL

// - Pipelined, parametrised N-bit comparator for the ALU/branch unit: EQ, NE, LT, GE (signed and unsigned).
// - Splits operands into STAGES equal slices, resolved MSB-slice first, one slice per pipeline stage.
// - Valid/ready handshake on both sides with full back-pressure, synchronous flush and a pass-through tag.

---
 rtl/compare_pipe_nb_pkg.sv | 40 ++++
 rtl/compare_pipe_nb_if.sv | 32 +++
 rtl/compare_pipe_nb_slice.sv | 25 ++
 rtl/compare_pipe_nb.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/compare_pipe_nb_pkg.sv
// Shared definitions for the pipelined comparator: op encodings (funct3 style),
// the op type and the final result decode used by the last pipeline stage.
package compare_pipe_nb_pkg;

    localparam int CMP_OP_W = 3;
    typedef logic [CMP_OP_W-1:0] cmp_op_t;

    localparam cmp_op_t CMP_EQ  = 3'b000;
    localparam cmp_op_t CMP_NE  = 3'b001;
    localparam cmp_op_t CMP_LT  = 3'b100;
    localparam cmp_op_t CMP_GE  = 3'b101;
    localparam cmp_op_t CMP_LTU = 3'b110;
    localparam cmp_op_t CMP_GEU = 3'b111;

    typedef struct packed {
        logic ill;
        logic res;
    } cmp_res_t;

    // LT/GE are the signed pair; flipping both MSBs turns them into unsigned compares.
    function automatic logic is_signed_op(cmp_op_t op);
        return (op[2:1] == 2'b10);
    endfunction

    // Map the resolved (lt, eq) pair onto the requested op; unknown ops give 0 + illegal.
    function automatic cmp_res_t cmp_decode(cmp_op_t op, logic lt, logic eq);
        cmp_res_t r;
        r.ill = 1'b0;
        r.res = 1'b0;
        case (op)
            CMP_EQ:           r.res = eq;
            CMP_NE:           r.res = ~eq;
            CMP_LT, CMP_LTU:  r.res = lt;
            CMP_GE, CMP_GEU:  r.res = ~lt;
            default:          r.ill = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/compare_pipe_nb_if.sv
// Handshake bundle for the comparator: request side (op, operands, tag) and
// result side (result, illegal flag, tag), each with valid/ready, plus flush.
interface compare_pipe_nb_if #(
    parameter int N     = 32,
    parameter int TAG_W = 5
);
    import compare_pipe_nb_pkg::*;

    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    cmp_op_t          op_i;
    logic [N-1:0]     a_i;
    logic [N-1:0]     b_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [N-1:0]     result_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output flush_i, in_valid_i, op_i, a_i, b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, illegal_o, tag_o
    );

    modport slave (
        input  flush_i, in_valid_i, op_i, a_i, b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, illegal_o, tag_o
    );

endinterface

// File: rtl/compare_pipe_nb_slice.sv
// Combinational unsigned compare of one W-bit slice, rippling from MSB to LSB.
module compare_pipe_nb_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o,
    output logic         eq_o
);

    // Walk from the MSB: the first differing bit decides less-than.
    always_comb begin
        logic lt_v;
        logic eq_v;
        lt_v = 1'b0;
        eq_v = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            lt_v = lt_v | (eq_v & ~a_i[i] & b_i[i]);
            eq_v = eq_v & ~(a_i[i] ^ b_i[i]);
        end
        lt_o = lt_v;
        eq_o = eq_v;
    end

endmodule

// File: rtl/compare_pipe_nb.sv
// Pipelined N-bit comparator: operands are resolved one W-bit slice per stage,
// MSB slice first, behind a ripple-stall valid/ready pipeline with flush.
module compare_pipe_nb
    import compare_pipe_nb_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input logic              clk_i,
    input logic              rstn_i,
    compare_pipe_nb_if.slave bus
);

    localparam int W = N / STAGES;

    if ((N % STAGES) != 0) begin : g_bad_split
        $error("compare_pipe_nb: N must be a multiple of STAGES");
    end

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;
    logic              in_rdy;
    logic              accept;

    // Stall chain: a stage moves when the next one is empty or moving; last on out_ready.
    always_comb begin
        logic [STAGES:0] free;
        free         = '0;
        adv          = '0;
        free[STAGES] = bus.out_ready_i;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s]  = vld[s] & free[s+1];
            free[s] = ~vld[s] | adv[s];
        end
        in_rdy = free[0] & ~bus.flush_i;
    end

    assign bus.in_ready_o = in_rdy;
    assign accept         = bus.in_valid_i & in_rdy;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Bits of each operand still unresolved on entry to this stage.
        localparam int RW = N - k * W;

        logic [RW-1:0]    a_src;
        logic [RW-1:0]    b_src;
        cmp_op_t          op_src;
        logic [TAG_W-1:0] tag_src;
        logic             lt_src;
        logic             eq_src;
        logic             load;
        logic             lt_sl;
        logic             eq_sl;
        logic             lt_nx;
        logic             eq_nx;
        logic             vld_d;
        logic             vld_q;
        logic [TAG_W-1:0] tag_q;

        if (k == 0) begin : g_src_in
            // Signed ops: flip both MSBs so the unsigned ripple gives the signed order.
            always_comb begin
                a_src = bus.a_i;
                b_src = bus.b_i;
                if (is_signed_op(bus.op_i)) begin
                    a_src[RW-1] = ~bus.a_i[N-1];
                    b_src[RW-1] = ~bus.b_i[N-1];
                end
            end
            assign op_src  = bus.op_i;
            assign tag_src = bus.tag_i;
            assign lt_src  = 1'b0;
            assign eq_src  = 1'b1;
            assign load    = accept;
        end else begin : g_src_prev
            assign a_src   = g_stage[k-1].g_mid.a_q;
            assign b_src   = g_stage[k-1].g_mid.b_q;
            assign op_src  = g_stage[k-1].g_mid.op_q;
            assign tag_src = g_stage[k-1].tag_q;
            assign lt_src  = g_stage[k-1].g_mid.lt_q;
            assign eq_src  = g_stage[k-1].g_mid.eq_q;
            assign load    = adv[k-1];
        end

        compare_pipe_nb_slice #(.W(W)) u_slice (
            .a_i  (a_src[RW-1 -: W]),
            .b_i  (b_src[RW-1 -: W]),
            .lt_o (lt_sl),
            .eq_o (eq_sl)
        );

        assign lt_nx = lt_src | (eq_src & lt_sl);
        assign eq_nx = eq_src & eq_sl;

        // Valid next-state: flush wins, then a new op, then draining to the next stage.
        always_comb begin
            vld_d = vld_q;
            if (bus.flush_i) begin
                vld_d = 1'b0;
            end else if (load) begin
                vld_d = 1'b1;
            end else if (adv[k]) begin
                vld_d = 1'b0;
            end
        end

        // Valid bit and tag register of this stage; tag only changes on a new op.
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                vld_q <= 1'b0;
                tag_q <= '0;
            end else begin
                vld_q <= vld_d;
                if (load) begin
                    tag_q <= tag_src;
                end
            end
        end

        assign vld[k] = vld_q;

        if (k < STAGES - 1) begin : g_mid
            cmp_op_t          op_q;
            logic             lt_q;
            logic             eq_q;
            logic [RW-W-1:0]  a_q;
            logic [RW-W-1:0]  b_q;

            // Partial result plus the lower slices still to be compared downstream.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    op_q <= '0;
                    lt_q <= 1'b0;
                    eq_q <= 1'b0;
                    a_q  <= '0;
                    b_q  <= '0;
                end else if (load) begin
                    op_q <= op_src;
                    lt_q <= lt_nx;
                    eq_q <= eq_nx;
                    a_q  <= a_src[RW-W-1:0];
                    b_q  <= b_src[RW-W-1:0];
                end
            end
        end else begin : g_last
            cmp_res_t dec;
            logic     res_q;
            logic     ill_q;

            assign dec = cmp_decode(op_src, lt_nx, eq_nx);

            // Final decoded result, held while the consumer stalls.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    res_q <= 1'b0;
                    ill_q <= 1'b0;
                end else if (load) begin
                    res_q <= dec.res;
                    ill_q <= dec.ill;
                end
            end

            assign bus.out_valid_o = vld_q;
            assign bus.result_o    = {{(N-1){1'b0}}, res_q};
            assign bus.illegal_o   = ill_q;
            assign bus.tag_o       = tag_q;
        end
    end

endmodule
